// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands LSB-first,
// one bit per clock, and reports carry-out and signed overflow when the last bit is done.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fa_s, fa_c;
  logic           last;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B at load and seed the carry with mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= mode ? ~b : b;
            carry <= mode;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout <= fa_c;
            // carry still holds the carry into the MSB at this point
            ovf  <= carry ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
